// File: rtl/regfile_array_wb.sv
// regfile_array_wb: 32x64 register-file write side with hardwired zero register and optional write-through bypass.
module regfile_array_wb #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_IDX = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [NREGS-1:0][WIDTH-1:0]  regs_out,
    output logic                         wr_ack,
    output logic                         wr_dropped
);
    localparam logic [AW-1:0] ZA = AW'(ZERO_IDX);
    logic [NREGS-1:0][WIDTH-1:0] q;
    logic [NREGS-1:0] dec;
    logic hit_zero;
    // Decode is gated by wr_en so an unknown address on an idle cycle selects nothing.
    always_comb begin
        hit_zero = wr_en && (wr_addr == ZA);
        dec = (wr_en && (wr_addr != ZA)) ? NREGS'(1) << wr_addr : '0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            q          <= '0;
            wr_ack     <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            for (int k = 0; k < NREGS; k++)
                if (dec[k]) q[k] <= wr_data;
            wr_ack     <= |dec;
            wr_dropped <= hit_zero;
        end
    end
    always_comb begin
        regs_out = '0;
        for (int k = 0; k < NREGS; k++)
            regs_out[k] = (!reset || k == ZERO_IDX) ? '0 :
                          (BYPASS != 0 && dec[k]) ? wr_data : q[k];
    end
endmodule

// File: tb/tb_regfile_array_wb.sv
// tb_regfile_array_wb: scoreboard bench driving bypass and non-bypass instances with shared stimulus.
module tb_regfile_array_wb;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [31:0][63:0] regs_out, regs0;
    logic wr_ack, wr_dropped, ack0, drop0;

    typedef struct {
        logic [31:0][63:0] r1;
        logic [31:0][63:0] r0;
        logic ack;
        logic drop;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_x;
    logic [31:0][63:0] mdl = '0;
    logic m_ack = 1'bx;
    logic m_drop = 1'bx;
    int checks = 0;
    int fails = 0;

    regfile_array_wb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .regs_out(regs_out), .wr_ack(wr_ack), .wr_dropped(wr_dropped)
    );
    regfile_array_wb #(.BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .regs_out(regs0), .wr_ack(ack0), .wr_dropped(drop0)
    );

    always #5 clk = ~clk;

    function automatic int first_diff(input logic [31:0][63:0] a, input logic [31:0][63:0] b);
        for (int k = 0; k < 32; k++)
            if (a[k] !== b[k]) return k;
        return 0;
    endfunction

    // Scoreboard: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            int k;
            mon_x = q_exp.pop_front();
            checks++;
            if (regs_out !== mon_x.r1) begin
                fails++;
                k = first_diff(regs_out, mon_x.r1);
                $display("FAIL regs_bypass t=%0t k=%0d actual=%h required=%h", $time, k, regs_out[k], mon_x.r1[k]);
            end
            checks++;
            if (regs0 !== mon_x.r0) begin
                fails++;
                k = first_diff(regs0, mon_x.r0);
                $display("FAIL regs_nobypass t=%0t k=%0d actual=%h required=%h", $time, k, regs0[k], mon_x.r0[k]);
            end
            if (!$isunknown({mon_x.ack, mon_x.drop})) begin
                checks++;
                if ({wr_ack, wr_dropped, ack0, drop0} !== {mon_x.ack, mon_x.drop, mon_x.ack, mon_x.drop}) begin
                    fails++;
                    $display("FAIL flags t=%0t actual ack/drop=%b%b ack0/drop0=%b%b required=%b%b",
                             $time, wr_ack, wr_dropped, ack0, drop0, mon_x.ack, mon_x.drop);
                end
            end
        end
    end

    task automatic put(input logic r, input logic e, input logic [4:0] a, input logic [63:0] d);
        exp_t x;
        reset = r; wr_en = e; wr_addr = a; wr_data = d;
        for (int k = 0; k < 32; k++) begin
            x.r0[k] = r ? mdl[k] : '0;
            x.r1[k] = (r && e === 1'b1 && a === 5'(k) && k != 31) ? d : x.r0[k];
        end
        x.ack = m_ack;
        x.drop = m_drop;
        q_exp.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            mdl = '0; m_ack = 1'b0; m_drop = 1'b0;
        end else begin
            m_ack = (wr_en === 1'b1) && (wr_addr !== 5'd31);
            m_drop = (wr_en === 1'b1) && (wr_addr === 5'd31);
            if (m_ack) mdl[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic test_reset();
        put(0, 1, 5, 64'hDEAD); tick();
        put(0, 1, 5, 64'hDEAD); #2;
        checks++;
        if (regs_out !== '0 || regs0 !== '0 || wr_ack !== 1'b0 || wr_dropped !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold actual ack=%b drop=%b r5=%h required zeros", wr_ack, wr_dropped, regs_out[5]);
        end
        tick();
        put(1, 0, 0, 0); #2;
        checks++;
        if (regs_out !== '0 || regs0 !== '0) begin
            fails++;
            $display("FAIL reset_release actual r5=%h required 0", regs_out[5]);
        end
        tick();
    endtask

    task automatic test_write_read();
        put(1, 1, 13, 64'd13); tick();
        put(1, 1, 9, 64'd1309); #2;
        checks++;
        if (wr_ack !== 1'b1) begin fails++; $display("FAIL ack_first actual=%b required=1", wr_ack); end
        tick();
        put(1, 0, 0, 0); #2;
        checks++;
        if (wr_ack !== 1'b1 || regs_out[13] !== 64'd13 || regs_out[9] !== 64'd1309) begin
            fails++;
            $display("FAIL write_read actual ack=%b r13=%0d r9=%0d required 1/13/1309", wr_ack, regs_out[13], regs_out[9]);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        put(1, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF); #2;
        checks++;
        if (regs_out[31] !== '0 || regs0[31] !== '0) begin
            fails++; $display("FAIL zero_same_cycle actual=%h required 0", regs_out[31]);
        end
        tick();
        put(1, 0, 0, 0); #2;
        checks++;
        if (wr_dropped !== 1'b1 || wr_ack !== 1'b0 || regs_out[31] !== '0) begin
            fails++;
            $display("FAIL zero_after actual drop=%b ack=%b r31=%h required 1/0/0", wr_dropped, wr_ack, regs_out[31]);
        end
        tick();
    endtask

    task automatic test_bypass();
        put(1, 1, 7, 64'h1); tick();
        put(1, 1, 7, 64'h2); #2;
        checks++;
        if (regs_out[7] !== 64'h2 || regs0[7] !== 64'h1) begin
            fails++; $display("FAIL bypass_before actual=%h/%h required 2/1", regs_out[7], regs0[7]);
        end
        tick();
        put(1, 0, 0, 0); #2;
        checks++;
        if (regs_out[7] !== 64'h2 || regs0[7] !== 64'h2) begin
            fails++; $display("FAIL bypass_after actual=%h/%h required 2/2", regs_out[7], regs0[7]);
        end
        tick();
    endtask

    task automatic test_overwrite();
        put(1, 1, 0, 64'hA); tick();
        put(1, 1, 0, 64'hB); #2;
        checks++;
        if (regs0[0] !== 64'hA) begin fails++; $display("FAIL overwrite_a actual=%h required a", regs0[0]); end
        tick();
        put(1, 0, 0, 64'hC); #2;
        checks++;
        if (regs_out[0] !== 64'hB || regs0[0] !== 64'hB) begin
            fails++; $display("FAIL hold_b actual=%h/%h required b", regs_out[0], regs0[0]);
        end
        tick();
        put(1, 0, 5'bx, 64'hC); #2;
        checks++;
        if (regs_out[0] !== 64'hB || $isunknown(regs_out)) begin
            fails++; $display("FAIL x_addr_idle actual=%h required b", regs_out[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 30; i++) begin put(1, 1, 5'(i), 64'(i)); tick(); end
        put(0, 0, 0, 0); tick();
        put(1, 0, 0, 0); #2;
        checks++;
        if (regs_out !== '0 || regs0 !== '0) begin
            fails++; $display("FAIL reset_mid actual r30=%h required 0", regs0[30]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            put(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 31)), {$urandom, $urandom});
            tick();
        end
        for (int i = 0; i < 4; i++) begin put(1, 1, 3, 64'(i + 100)); tick(); end
        put(1, 0, 0, 0); #2;
        checks++;
        if (regs_out[3] !== 64'd103) begin fails++; $display("FAIL b2b_same actual=%0d required 103", regs_out[3]); end
        tick();
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_overwrite();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
